// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between an
// instruction-fetch port and a data port. Data normally wins; a bounded
// starvation counter hands the slot to fetch after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  // Owner of the memory response arriving this cycle.
  typedef enum logic [1:0] {IDLE, RD_IF, RD_DM, WR_DM} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_starve;
  logic          r_drop;
  logic          w_starved;
  logic          w_if_gnt;
  logic          w_dm_gnt;

  // Fetch only beats a pending data request once it has waited long enough.
  // Grants are masked by rst_n so nothing leaves the block while in reset.
  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign w_if_gnt  = rst_n && if_req && !halted && (!dm_req || w_starved);
  assign w_dm_gnt  = rst_n && dm_req && !w_if_gnt;

  // State register: owner of next cycle's read data, plus the flush-drop flag.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= w_if_gnt && flush;
    end
  end

  // Next owner follows whichever grant (if any) was given this cycle.
  always_comb begin
    w_next = IDLE;
    if (w_if_gnt)      w_next = RD_IF;
    else if (w_dm_gnt) w_next = dm_we ? WR_DM : RD_DM;
  end

  // Outputs: grant side drives the memory, state side returns the response.
  always_comb begin
    if_gnt    = w_if_gnt;
    dm_gnt    = w_dm_gnt;
    mem_en    = w_if_gnt || w_dm_gnt;
    mem_we    = w_dm_gnt && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
    end else if (w_dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
    if_valid = 1'b0;
    if_rdata = '0;
    dm_valid = 1'b0;
    dm_rdata = '0;
    case (r_state)
      RD_IF: if (!(r_drop || flush)) begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
      RD_DM: begin
        dm_valid = 1'b1;
        dm_rdata = mem_rdata;
      end
      WR_DM: dm_valid = 1'b1;
      default: ;
    endcase
  end

  // Starvation counter: counts data grants that pass over a waiting fetch.
  // A halted core is not starving, so the count is frozen while halted.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      r_starve <= '0;
    else if (!if_req || w_if_gnt)
      r_starve <= '0;
    else if (!halted && w_dm_gnt && !w_starved)
      r_starve <= r_starve + SW'(1);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the arbiter and a shadow memory.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 3;

  logic          clk1 = 1'b0;
  logic          rst_n, halted, flush;
  logic          if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_valid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk1 = ~clk1;

  // Physical memory seen by the DUT (read-first, one-cycle latency).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  // refm: what memory should contain; pending response described as a kind.
  logic [DW-1:0] refm [0:(1<<AW)-1];
  int            m_cnt;   // data grants taken while fetch waited
  int            m_kind;  // 0 none, 1 fetch, 2 load, 3 store
  logic [DW-1:0] m_data;
  bit            m_drop;

  bit            e_ig, e_dg, e_en, e_we, e_iv, e_dv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_ir, e_dr;

  task automatic model_eval();
    e_ig = 0; e_dg = 0; e_en = 0; e_we = 0; e_iv = 0; e_dv = 0;
    e_addr = '0; e_wd = '0; e_ir = '0; e_dr = '0;
    if (rst_n) begin
      e_ig = if_req && !halted && (!dm_req || m_cnt == SM);
      e_dg = dm_req && !e_ig;
      e_en = e_ig || e_dg;
      e_we = e_dg && dm_we;
      e_addr = e_ig ? if_addr : dm_addr;
      e_wd = e_dg ? dm_wdata : '0;
      e_iv = (m_kind == 1) && !m_drop && !flush;
      e_ir = e_iv ? m_data : '0;
      e_dv = (m_kind >= 2);
      e_dr = (m_kind == 2) ? m_data : '0;
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      m_cnt = 0; m_kind = 0; m_drop = 0; m_data = '0;
      return;
    end
    m_drop = e_ig && flush;
    if (e_ig) begin
      m_kind = 1; m_data = refm[if_addr];
    end else if (e_dg) begin
      m_kind = dm_we ? 3 : 2; m_data = refm[dm_addr];
      if (dm_we) refm[dm_addr] = dm_wdata;
    end else m_kind = 0;
    if (!if_req || e_ig) m_cnt = 0;
    else if (!halted && e_dg && m_cnt < SM) m_cnt++;
  endtask

  // Advance one clock: model follows the edge, then return to the negedge.
  task automatic tick();
    @(posedge clk1);
    model_commit();
    @(negedge clk1);
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; halted = 0; flush = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; idle_inputs(); if_req = 1; dm_req = 1; dm_we = 1;
    dm_addr = 10'd4; if_addr = 10'd2; dm_wdata = 32'hdeadbeef;
    model_commit();
    repeat (2) @(negedge clk1);
    #1;
    n_chk++;
    if ({if_gnt, dm_gnt, mem_en, mem_we, if_valid, dm_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 000000",
               {if_gnt, dm_gnt, mem_en, mem_we, if_valid, dm_valid});
    end
    n_chk++;
    if ({if_rdata, dm_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h expected 0", if_rdata, dm_rdata);
    end
    @(negedge clk1);
    rst_n = 1; idle_inputs();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 10'd5;
    #1; model_eval();
    n_chk++;
    if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL fetch_gnt: got gnt/en/we=%b addr=%0d expected 1010 addr=5",
               {if_gnt, dm_gnt, mem_en, mem_we}, mem_addr);
    end
    tick();
    if_req = 0;
    #1; model_eval();
    n_chk++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h2801000a) begin
      n_fail++;
      $display("FAIL fetch_data: got v=%b d=%h expected v=1 d=2801000a", if_valid, if_rdata);
    end
    tick();
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
    want = refm[9];
    if_req = 1; if_addr = 10'd6; dm_req = 1; dm_we = 0; dm_addr = 10'd9;
    #1; model_eval();
    n_chk++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 10'd9) begin
      n_fail++;
      $display("FAIL collide_gnt: got dm=%b if=%b addr=%0d expected dm=1 if=0 addr=9",
               dm_gnt, if_gnt, mem_addr);
    end
    tick();
    if_req = 0; dm_req = 0;
    #1; model_eval();
    n_chk++;
    if (dm_valid !== 1'b1 || dm_rdata !== want || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_data: got v=%b d=%h ifv=%b expected v=1 d=%h ifv=0",
               dm_valid, dm_rdata, if_valid, want);
    end
    tick();
  endtask

  task automatic test_starve();
    bit pat_if [5] = '{0, 0, 0, 1, 0};
    if_req = 1; if_addr = 10'd7; dm_req = 1; dm_we = 0;
    for (int k = 0; k < 5; k++) begin
      dm_addr = AW'(k + 1);
      #1; model_eval();
      n_chk++;
      if (if_gnt !== pat_if[k] || dm_gnt !== !pat_if[k]) begin
        n_fail++;
        $display("FAIL starve_c%0d: got if=%b dm=%b expected if=%b dm=%b",
                 k, if_gnt, dm_gnt, pat_if[k], !pat_if[k]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_store();
    dm_req = 1; dm_we = 1; dm_addr = 10'd3; dm_wdata = 32'h0ce77800;
    #1; model_eval();
    n_chk++;
    if (dm_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== 10'd3 || mem_wdata !== 32'h0ce77800) begin
      n_fail++;
      $display("FAIL store_req: got g=%b en=%b we=%b a=%0d wd=%h expected 1 1 1 3 0ce77800",
               dm_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    dm_we = 0; dm_wdata = '0;
    #1; model_eval();
    n_chk++;
    if (dm_valid !== 1'b1 || dm_rdata !== '0) begin
      n_fail++; $display("FAIL store_ack: got v=%b d=%h expected v=1 d=0", dm_valid, dm_rdata);
    end
    tick();
    dm_req = 0;
    #1;
    n_chk++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'h0ce77800) begin
      n_fail++;
      $display("FAIL store_readback: got v=%b d=%h expected v=1 d=0ce77800", dm_valid, dm_rdata);
    end
    model_eval();
    tick();
  endtask

  task automatic test_flush_halt();
    // flush on the response cycle
    if_req = 1; if_addr = 10'd2;
    #1; model_eval();
    tick();
    if_req = 0; flush = 1;
    #1; model_eval();
    n_chk++;
    if (if_valid !== 1'b0 || if_rdata !== '0) begin
      n_fail++; $display("FAIL flush_resp: got v=%b d=%h expected v=0 d=0", if_valid, if_rdata);
    end
    tick();
    // flush on the grant cycle: grant still given, response dropped
    if_req = 1; flush = 1;
    #1; model_eval();
    n_chk++;
    if (if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL flush_gnt: got %b expected 1", if_gnt);
    end
    tick();
    if_req = 0; flush = 0;
    #1; model_eval();
    n_chk++;
    if (if_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: got %b expected 0", if_valid);
    end
    tick();
    // halted: fetch blocked for 10 cycles while loads are served
    halted = 1; if_req = 1; dm_req = 1; dm_we = 0;
    for (int k = 0; k < 10; k++) begin
      dm_addr = AW'($urandom_range(0, 31));
      #1; model_eval();
      n_chk++;
      if (if_gnt !== 1'b0 || dm_gnt !== 1'b1 || (k > 0 && dm_valid !== 1'b1) ||
          dm_rdata !== e_dr) begin
        n_fail++;
        $display("FAIL halt_c%0d: got if=%b dm=%b v=%b d=%h expected 0 1 %b %h",
                 k, if_gnt, dm_gnt, dm_valid, dm_rdata, k > 0, e_dr);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    dm_req = 1; dm_we = 0; dm_addr = 10'd11;
    #1; model_eval();
    tick();
    dm_req = 0; rst_n = 0;
    #1;
    n_chk++;
    if (dm_valid !== 1'b0 || dm_rdata !== '0) begin
      n_fail++; $display("FAIL rst_mid: got v=%b d=%h expected 0 0", dm_valid, dm_rdata);
    end
    model_commit();
    tick();
    rst_n = 1;
    #1;
    n_chk++;
    if (dm_valid !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_release: got dv=%b iv=%b expected 0 0", dm_valid, if_valid);
    end
    model_eval();
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if_req   = ($urandom_range(0, 3) != 0);
      dm_req   = ($urandom_range(0, 1) != 0);
      dm_we    = ($urandom_range(0, 2) == 0);
      halted   = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 5) == 0);
      if_addr  = AW'($urandom_range(0, 15));
      dm_addr  = AW'($urandom_range(0, 15));
      dm_wdata = $urandom;
      #1; model_eval();
      n_chk++;
      if ({if_gnt, dm_gnt, mem_en, mem_we} !== {e_ig, e_dg, e_en, e_we} ||
          (e_en && mem_addr !== e_addr) || mem_wdata !== e_wd) begin
        n_fail++;
        $display("FAIL rand_req c%0d: got g=%b a=%0d wd=%h expected g=%b a=%0d wd=%h",
                 k, {if_gnt, dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata,
                 {e_ig, e_dg, e_en, e_we}, e_addr, e_wd);
      end
      n_chk++;
      if (if_valid !== e_iv || if_rdata !== e_ir || dm_valid !== e_dv || dm_rdata !== e_dr) begin
        n_fail++;
        $display("FAIL rand_rsp c%0d: got iv=%b id=%h dv=%b dd=%h expected iv=%b id=%h dv=%b dd=%h",
                 k, if_valid, if_rdata, dm_valid, dm_rdata, e_iv, e_ir, e_dv, e_dr);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      mem[i] = v; refm[i] = v;
    end
    mem[5] = 32'h2801000a; refm[5] = 32'h2801000a;
    @(negedge clk1);
    test_reset();
    test_fetch();
    test_collision();
    test_starve();
    test_store();
    test_flush_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
